id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_if.sv | 51 +++++
 rtl/id_ex_stage.sv | 123 ++++++++++++
 2 files changed

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute handshake and payload bundle.
interface id_ex_stage_if;
  logic        ds_to_es_valid;
  logic        es_allowin;
  logic [14:0] id_alu_control;
  logic [31:0] id_pc;
  logic [4:0]  id_rs_addr;
  logic [4:0]  id_rt_addr;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic [4:0]  id_sa;
  logic        id_src_a_sel;
  logic        id_src_b_sel;
  logic        id_wreg_en;
  logic [4:0]  id_wreg_addr;

  modport master (
    output ds_to_es_valid,
    output id_alu_control,
    output id_pc,
    output id_rs_addr,
    output id_rt_addr,
    output id_rs_data,
    output id_rt_data,
    output id_imm,
    output id_sa,
    output id_src_a_sel,
    output id_src_b_sel,
    output id_wreg_en,
    output id_wreg_addr,
    input  es_allowin
  );

  modport slave (
    input  ds_to_es_valid,
    input  id_alu_control,
    input  id_pc,
    input  id_rs_addr,
    input  id_rt_addr,
    input  id_rs_data,
    input  id_rt_data,
    input  id_imm,
    input  id_sa,
    input  id_src_a_sel,
    input  id_src_b_sel,
    input  id_wreg_en,
    input  id_wreg_addr,
    output es_allowin
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand select and MEM/WB bypass.
// Define ID_EX_FWD_EN to enable forwarding from the ms/ws buses.
module id_ex_stage (
  input  logic        clk,
  input  logic        resetn,
  id_ex_stage_if.slave ds,
  input  logic        ms_wreg_en,
  input  logic [4:0]  ms_wreg_addr,
  input  logic [31:0] ms_wdata,
  input  logic        ws_wreg_en,
  input  logic [4:0]  ws_wreg_addr,
  input  logic [31:0] ws_wdata,
  input  logic        es_stall,
  input  logic        ms_allowin,
  input  logic        flush,
  output logic        es_valid,
  output logic        es_to_ms_valid,
  output logic [14:0] es_alu_control,
  output logic [31:0] es_da,
  output logic [31:0] es_db,
  output logic [31:0] es_pc,
  output logic        es_wreg_en,
  output logic [4:0]  es_wreg_addr,
  output logic [31:0] es_rt_value
);

  typedef struct packed {
    logic [14:0] alu;
    logic [31:0] da;
    logic [31:0] db;
    logic [31:0] pc;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] rt;
  } ex_t;

  logic        valid_q;
  ex_t         ex_q;
  ex_t         ex_d;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        allowin;

  assign allowin = !valid_q || (!es_stall && ms_allowin);
  assign ds.es_allowin = allowin;

`ifdef ID_EX_FWD_EN
  logic ms_rs_hit;
  logic ms_rt_hit;
  logic ws_rs_hit;
  logic ws_rt_hit;

  // r0 is hardwired, so a pending write to it never bypasses
  assign ms_rs_hit = ms_wreg_en && ms_wreg_addr == ds.id_rs_addr
                     && ds.id_rs_addr != 5'd0;
  assign ms_rt_hit = ms_wreg_en && ms_wreg_addr == ds.id_rt_addr
                     && ds.id_rt_addr != 5'd0;
  assign ws_rs_hit = ws_wreg_en && ws_wreg_addr == ds.id_rs_addr
                     && ds.id_rs_addr != 5'd0;
  assign ws_rt_hit = ws_wreg_en && ws_wreg_addr == ds.id_rt_addr
                     && ds.id_rt_addr != 5'd0;

  always_comb begin
    rs_val = ds.id_rs_data;
    if (ms_rs_hit)
      rs_val = ms_wdata;
    else if (ws_rs_hit)
      rs_val = ws_wdata;
  end

  always_comb begin
    rt_val = ds.id_rt_data;
    if (ms_rt_hit)
      rt_val = ms_wdata;
    else if (ws_rt_hit)
      rt_val = ws_wdata;
  end
`else
  logic unused_fwd;

  assign unused_fwd = ^{ms_wreg_en, ms_wreg_addr, ms_wdata,
                        ws_wreg_en, ws_wreg_addr, ws_wdata,
                        ds.id_rs_addr, ds.id_rt_addr};
  assign rs_val = ds.id_rs_data;
  assign rt_val = ds.id_rt_data;
`endif

  always_comb begin
    ex_d       = '0;
    ex_d.alu   = ds.id_alu_control;
    ex_d.da    = ds.id_src_a_sel ? {27'b0, ds.id_sa} : rs_val;
    ex_d.db    = ds.id_src_b_sel ? ds.id_imm : rt_val;
    ex_d.pc    = ds.id_pc;
    ex_d.wen   = ds.id_wreg_en;
    ex_d.waddr = ds.id_wreg_addr;
    ex_d.rt    = rt_val;
  end

  // flush beats capture; payload is only rewritten on an accepted instruction
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      ex_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (allowin) begin
      valid_q <= ds.ds_to_es_valid;
      if (ds.ds_to_es_valid)
        ex_q <= ex_d;
    end
  end

  assign es_valid       = valid_q;
  assign es_to_ms_valid = valid_q && !es_stall && !flush;
  assign es_alu_control = ex_q.alu;
  assign es_da          = ex_q.da;
  assign es_db          = ex_q.db;
  assign es_pc          = ex_q.pc;
  assign es_wreg_en     = ex_q.wen;
  assign es_wreg_addr   = ex_q.waddr;
  assign es_rt_value    = ex_q.rt;

endmodule
